// File: rtl/matrix_strip_serializer_if.sv
// rtl/matrix_strip_serializer_if.sv - pixel valid/ready stream into the strip serializer
interface matrix_strip_serializer_if;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;

  modport master (output pix_valid, output pix_data, input pix_ready);
  modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/matrix_strip_serializer.sv
// rtl/matrix_strip_serializer.sv - APA102-style strip serializer; MATRIX_BRIGHTNESS_PORT_EN adds a brightness port
module matrix_strip_serializer #(
  parameter int NUM_LEDS   = 64,
  parameter int CLK_DIV    = 4,
  parameter int BRIGHTNESS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
`ifdef MATRIX_BRIGHTNESS_PORT_EN
  input  logic [4:0] brightness,
`endif
  matrix_strip_serializer_if.slave pix,
  output logic       busy,
  output logic       frame_done,
  output logic       clock_1,
  output logic       strip_1
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam int              END_RAW  = 8 * ((NUM_LEDS + 15) / 16);
  localparam int              END_BITS = (END_RAW > 32) ? END_RAW : 32;
  localparam logic [9:0]      LAST_END = 10'(END_BITS - 1);
  localparam logic [9:0]      NUM_PIX  = 10'(NUM_LEDS);

  typedef enum logic [1:0] {S_IDLE, S_START, S_PIXEL, S_END} state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic             half;      // 0 = low phase of the strip clock, 1 = high phase
  logic [5:0]       bit_cnt;
  logic [9:0]       pix_cnt;
  logic [9:0]       end_cnt;
  logic [31:0]      shreg;
  logic             ready_r;
  logic             stall;

  logic             bit_end;
  logic             nx_half;
  logic             nx_last;
  logic [DIV_W-1:0] nx_div;
  logic             xfer;
  logic             more_pix;
  logic [4:0]       bright;
  logic [31:0]      word;

`ifdef MATRIX_BRIGHTNESS_PORT_EN
  logic [4:0] bright_r;
  assign bright = bright_r;
`else
  assign bright = 5'(BRIGHTNESS);
`endif

  assign xfer          = pix.pix_valid && ready_r;
  assign more_pix      = (pix_cnt < NUM_PIX);
  assign word          = {3'b111, bright, pix.pix_data[7:0], pix.pix_data[15:8], pix.pix_data[23:16]};
  assign pix.pix_ready = ready_r;

  // Next divider position; nx_last flags that the coming cycle closes the current bit.
  always_comb begin
    bit_end = half && (div == DIV_MAX);
    nx_div  = '0;
    nx_half = 1'b0;
    if (!bit_end) begin
      if (div == DIV_MAX) begin
        nx_div  = '0;
        nx_half = 1'b1;
      end else begin
        nx_div  = div + 1'b1;
        nx_half = half;
      end
    end
    nx_last = nx_half && (nx_div == DIV_MAX);
  end

  // Frame sequencer: the word boundary is the last high cycle of the previous bit, so a
  // transfer there costs no extra cycle; START hands over to PIXEL as that cycle begins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      div        <= '0;
      half       <= 1'b0;
      bit_cnt    <= '0;
      pix_cnt    <= '0;
      end_cnt    <= '0;
      shreg      <= '0;
      ready_r    <= 1'b0;
      stall      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      clock_1    <= 1'b0;
      strip_1    <= 1'b0;
`ifdef MATRIX_BRIGHTNESS_PORT_EN
      bright_r   <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start && !frame_done) begin
            state   <= S_START;
            busy    <= 1'b1;
            clock_1 <= 1'b0;
            strip_1 <= 1'b0;
            div     <= '0;
            half    <= 1'b0;
            bit_cnt <= '0;
            pix_cnt <= '0;
            end_cnt <= '0;
`ifdef MATRIX_BRIGHTNESS_PORT_EN
            bright_r <= brightness;
`endif
          end
        end

        S_START: begin
          div     <= nx_div;
          half    <= nx_half;
          clock_1 <= nx_half;
          if (bit_end) begin
            bit_cnt <= bit_cnt + 6'd1;
            strip_1 <= 1'b0;
          end else if (nx_last && (bit_cnt == 6'd31)) begin
            state   <= S_PIXEL;
            ready_r <= 1'b1;
          end
        end

        S_PIXEL: begin
          if (stall || (bit_end && ready_r)) begin
            // Boundary or stalled: load on transfer, otherwise park with the clock low.
            clock_1 <= 1'b0;
            div     <= '0;
            half    <= 1'b0;
            if (xfer) begin
              shreg   <= word;
              strip_1 <= word[31];
              bit_cnt <= '0;
              pix_cnt <= pix_cnt + 10'd1;
              ready_r <= 1'b0;
              stall   <= 1'b0;
            end else begin
              stall   <= 1'b1;
            end
          end else if (bit_end) begin
            clock_1 <= 1'b0;
            div     <= '0;
            half    <= 1'b0;
            if (bit_cnt == 6'd31) begin
              state   <= S_END;
              strip_1 <= 1'b1;
              end_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              strip_1 <= shreg[30];
              shreg   <= {shreg[30:0], 1'b0};
            end
          end else begin
            div     <= nx_div;
            half    <= nx_half;
            clock_1 <= nx_half;
            if (nx_last && (bit_cnt == 6'd31) && more_pix) begin
              ready_r <= 1'b1;
            end
          end
        end

        S_END: begin
          div     <= nx_div;
          half    <= nx_half;
          clock_1 <= nx_half;
          if (bit_end) begin
            if (end_cnt == LAST_END) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              strip_1    <= 1'b0;
              end_cnt    <= '0;
            end else begin
              end_cnt <= end_cnt + 10'd1;
              strip_1 <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_strip_serializer.sv
// tb/tb_matrix_strip_serializer.sv - directed bench for matrix_strip_serializer (MATRIX_BRIGHTNESS_PORT_EN aware)
module tb_matrix_strip_serializer;

`ifdef MATRIX_BRIGHTNESS_PORT_EN
  localparam logic [31:0] EXP_W1 = 32'hFF332211;
  localparam logic [31:0] EXP_W2 = 32'hFF0000FF;
`else
  localparam logic [31:0] EXP_W1 = 32'hE8332211;
  localparam logic [31:0] EXP_W2 = 32'hE80000FF;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fs = 1'b0;
  logic fs_x = 1'b0;
  logic [4:0] bright_in = 5'h1F;
  logic busy, frame_done, clock_1, strip_1;
  logic busy_b, done_b, clk1_b, d_b;
  logic busy_c, done_c, clk1_c, d_c;

  matrix_strip_serializer_if pif ();
  matrix_strip_serializer_if ifb ();
  matrix_strip_serializer_if ifc ();

  assign ifb.pix_valid = 1'b1;
  assign ifb.pix_data  = 24'h0;
  assign ifc.pix_valid = 1'b1;
  assign ifc.pix_data  = 24'h0;

  always #5 clk = ~clk;

  matrix_strip_serializer #(.NUM_LEDS(2), .CLK_DIV(2), .BRIGHTNESS(8)) dut (
    .clk(clk), .rst(rst), .frame_start(fs),
`ifdef MATRIX_BRIGHTNESS_PORT_EN
    .brightness(bright_in),
`endif
    .pix(pif), .busy(busy), .frame_done(frame_done), .clock_1(clock_1), .strip_1(strip_1));

  matrix_strip_serializer #(.NUM_LEDS(100), .CLK_DIV(1), .BRIGHTNESS(8)) dut_b (
    .clk(clk), .rst(rst), .frame_start(fs_x),
`ifdef MATRIX_BRIGHTNESS_PORT_EN
    .brightness(bright_in),
`endif
    .pix(ifb), .busy(busy_b), .frame_done(done_b), .clock_1(clk1_b), .strip_1(d_b));

  matrix_strip_serializer #(.NUM_LEDS(1), .CLK_DIV(1), .BRIGHTNESS(8)) dut_c (
    .clk(clk), .rst(rst), .frame_start(fs_x),
`ifdef MATRIX_BRIGHTNESS_PORT_EN
    .brightness(bright_in),
`endif
    .pix(ifc), .busy(busy_c), .frame_done(done_c), .clock_1(clk1_c), .strip_1(d_c));

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic clr = 1'b0;

  bit cap[$];
  logic prev_c1, prev_busy;
  int busy_rise, done_cyc, n_rise, n_done, n_xfer;
  logic pc_b, pc_c;
  int eb, ob, db, ec, oc, dc;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe strip_1 on each clock_1 rising edge and log frame events.
  always @(negedge clk) begin
    prev_c1   <= clock_1;
    prev_busy <= busy;
    pc_b      <= clk1_b;
    pc_c      <= clk1_c;
    if (clr) begin
      cap.delete();
      n_rise <= 0; n_done <= 0; n_xfer <= 0; busy_rise <= 0; done_cyc <= 0;
      eb <= 0; ob <= 0; db <= 0; ec <= 0; oc <= 0; dc <= 0;
    end else begin
      if (clock_1 && !prev_c1) cap.push_back(strip_1);
      if (busy && !prev_busy) begin busy_rise <= cyc; n_rise <= n_rise + 1; end
      if (frame_done) begin done_cyc <= cyc; n_done <= n_done + 1; end
      if (pif.pix_valid && pif.pix_ready) n_xfer <= n_xfer + 1;
      if (clk1_b && !pc_b) begin eb <= eb + 1; ob <= d_b ? ob + 1 : 0; end
      if (clk1_c && !pc_c) begin ec <= ec + 1; oc <= d_c ? oc + 1 : 0; end
      if (done_b) db <= db + 1;
      if (done_c) dc <= dc + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] word_at(input int i);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 32; b++)
      if (32 * i + b < cap.size()) w = {w[30:0], cap[32 * i + b]};
    return w;
  endfunction

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!pif.pix_ready && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) check("ready_timeout", 1'b0, 1'b1);
  endtask

  task automatic feed(input int stall);
    logic [23:0] px [2];
    px[0] = 24'h112233;
    px[1] = 24'hFF0000;
    for (int k = 0; k < 2; k++) begin
      if (k == 1 && stall > 0) begin
        pif.pix_valid = 1'b0;
        wait_ready();
        repeat (stall) begin @(posedge clk); #1; end
      end
      pif.pix_valid = 1'b1;
      pif.pix_data  = px[k];
      wait_ready();
      @(posedge clk); #1;
    end
    pif.pix_valid = 1'b0;
  endtask

  task automatic run_frame(input string nm, input int stall, input bit poke);
    int t;
    clear_mon();
    @(posedge clk); #1 fs = 1'b1; bright_in = 5'h1F;
    @(posedge clk); #1 fs = 1'b0; bright_in = 5'h00;
    fork
      feed(stall);
      begin
        if (poke) begin
          repeat (50) @(posedge clk);
          #1 fs = 1'b1;
          @(posedge clk); #1 fs = 1'b0;
        end
      end
    join
    t = 0;
    while (!frame_done && t < 3000) begin @(posedge clk); #1; t++; end
    check({nm, "_done_seen"}, frame_done, 1'b1);
    if (poke) begin fs = 1'b1; @(posedge clk); #1 fs = 1'b0; end
    repeat (10) @(posedge clk);
    #1;
    check({nm, "_edges"}, cap.size(), 128);
    check({nm, "_start"}, word_at(0), 32'h0);
    check({nm, "_word1"}, word_at(1), EXP_W1);
    check({nm, "_word2"}, word_at(2), EXP_W2);
    check({nm, "_end"}, word_at(3), 32'hFFFFFFFF);
    check({nm, "_len"}, done_cyc - busy_rise, 512 + stall);
    check({nm, "_xfers"}, n_xfer, 2);
    check({nm, "_frames"}, n_rise, 1);
    check({nm, "_dones"}, n_done, 1);
    check({nm, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    pif.pix_valid = 1'b0;
    pif.pix_data  = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_clock", clock_1, 1'b0);
    check("rst_strip", strip_1, 1'b0);
    check("rst_ready", pif.pix_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Abort a frame in the middle of the first pixel word.
    pif.pix_valid = 1'b1;
    pif.pix_data  = 24'h112233;
    fs = 1'b1;
    @(posedge clk); #1 fs = 1'b0;
    repeat (202) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_clock", clock_1, 1'b0);
    check("abort_strip", strip_1, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", pif.pix_ready, 1'b0);
    pif.pix_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    run_frame("frame", 0, 1'b0);
    run_frame("stall", 20, 1'b0);
    run_frame("ignore", 0, 1'b1);

    begin
      int t;
      clear_mon();
      @(posedge clk); #1 fs_x = 1'b1;
      @(posedge clk); #1 fs_x = 1'b0;
      t = 0;
      while ((db == 0 || dc == 0) && t < 10000) begin @(posedge clk); #1; t++; end
      repeat (4) @(posedge clk);
      #1;
      check("n100_edges", eb, 3288);
      check("n100_end_ones", ob, 56);
      check("n100_busy", busy_b, 1'b0);
      check("n1_edges", ec, 96);
      check("n1_end_ones", oc, 32);
      check("n1_busy", busy_c, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
